pipeline_control: RTL and testbench
===================================

// Module: pipeline_control
// PURPOSE
//  Hazard/exception controller for the five-stage Y86-64 pipeline. Drives stall/bubble of
//  F/D/E/M/W registers (incl. M_bubble into memory_register) and set_cc, halts the core on
//  non-AOK status reaching W, keeps saturating performance counters. Sits beside the datapath.
// PARAMETERS
//  CNT_W  32  width of each performance counter
// PORTS
//  clock             in   1      pipeline clock, all state on posedge
//  reset             in   1      asynchronous, active-high
//  D_icode           in   4      icode in decode register
//  E_icode           in   4      icode in execute register
//  M_icode           in   4      icode in memory register
//  E_dstm            in   4      dstM of execute-stage instr (4'hF = RNONE)
//  d_srca, d_srcb    in   4      decode-stage source regs (4'hF = RNONE)
//  e_cnd             in   1      branch condition computed in E
//  m_status          in   2      status leaving memory stage
//  W_status          in   2      status in writeback register
//  F_stall, D_stall, W_stall          out 1  hold stage register
//  D_bubble, E_bubble, M_bubble       out 1  load NOP (icode 4'd1) into stage register
//  set_cc            out  1      enable CC update in E
//  halted            out  1      core stopped
//  cpu_status        out  2      latched architectural status
//  cyc_count, stall_count, bubble_count, mispredict_count  out CNT_W  perf counters
// BEHAVIOUR
//  Stall/bubble/set_cc combinational from inputs + state (same-cycle); halted, cpu_status,
//  counters registered.
//  Reset (async, while high): D/E/M_bubble=1, all stalls 0, set_cc=0, halted=0,
//  cpu_status=SAOK, counters 0, state RUN.
//  Terms: load_use = E_icode in {MRMOVQ,POPQ} && E_dstm!=RNONE && E_dstm in {d_srca,d_srcb};
//   ret_pend = RET in {D_icode,E_icode,M_icode}; mispred = E_icode==JXX && !e_cnd;
//   exc_m = m_status!=SAOK; exc_w = W_status!=SAOK.
//  RUN: F_stall=load_use|ret_pend; D_stall=load_use; D_bubble=mispred|(ret_pend&!load_use);
//   E_bubble=mispred|load_use; M_bubble=exc_m|exc_w; W_stall=exc_w;
//   set_cc=(E_icode==OPQ)&!exc_m&!exc_w.
//  Priority: load_use+ret_pend -> stall D, no D bubble; mispred overrides ret D-stall-free.
//  FSM: RUN --(posedge with exc_w)--> HALTED, cpu_status<=W_status. HALTED absorbing;
//   exit only by reset. HALTED: F/D/W_stall=1, M_bubble=1, D/E_bubble=0, set_cc=0, halted=1.
//  Counters (RUN only, frozen in HALTED): cyc_count +1 each cycle; stall_count +1 if
//   F_stall|D_stall; bubble_count +1 if any bubble; mispredict_count +1 if mispred.
//   Saturate at all-ones, no wrap. Halting-edge cycle still counts.
//  Reset mid-operation: immediate return to reset values regardless of state.
// STRUCTURE
//  Package y86_pkg: icode constants (IHALT 0..IPOPQ 4'hB), RNONE 4'hF,
//   status SAOK=0, SHLT=1, SADR=2, SINS=3.
//  Sub-module sat_counter #(CNT_W) (clock, reset, inc, count) instanced 4x.
// TESTING
//  Load-use: E_icode=5, E_dstm=3, d_srca=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; stall_count+1.
//  Ret: D_icode=9 then advancing to E, M (3 cycles) -> F_stall=1, D_bubble=1 each cycle, then 0.
//  Mispredict: E_icode=7, e_cnd=0 -> D_bubble=E_bubble=1, mispredict_count 0->1; e_cnd=1 -> none.
//  Exception: m_status=2, E_icode=6 -> M_bubble=1, set_cc=0; next W_status=2 -> W_stall=1,
//   following cycle halted=1, cpu_status=2, counters frozen for 10 cycles.
//  Reset in HALTED: reset pulse mid-cycle -> halted=0, cpu_status=0, bubbles=1 immediately.
//  Saturation (CNT_W=4): 20 load-use cycles -> stall_count=15, cyc_count=15.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline control logic.
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } ctl_state_e;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) count_d = count_q + ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pipeline_control.sv
// Hazard/exception controller for the five-stage Y86-64 pipeline with
// halt FSM and saturating performance counters.
module pipeline_control
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       E_dstm,
  input  logic [3:0]       d_srca,
  input  logic [3:0]       d_srcb,
  input  logic             e_cnd,
  input  logic [1:0]       m_status,
  input  logic [1:0]       W_status,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic             halted,
  output logic [1:0]       cpu_status,
  output logic [CNT_W-1:0] cyc_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] mispredict_count
);
  ctl_state_e state_q, state_d;
  logic [1:0] status_q, status_d;

  logic load_use, ret_pend, mispred, exc_m, exc_w, run_active;

  assign load_use = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstm != RNONE) &&
                    ((E_dstm == d_srca) || (E_dstm == d_srcb));
  assign ret_pend = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign mispred  = (E_icode == IJXX) && !e_cnd;
  assign exc_m    = (m_status != SAOK);
  assign exc_w    = (W_status != SAOK);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      status_q <= SAOK;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    set_cc   = 1'b0;
    case (state_q)
      ST_RUN: begin
        F_stall  = load_use | ret_pend;
        D_stall  = load_use;
        // A pending ret only bubbles D when D is not already being held for a load.
        D_bubble = mispred | (ret_pend & ~load_use);
        E_bubble = mispred | load_use;
        M_bubble = exc_m | exc_w;
        W_stall  = exc_w;
        set_cc   = (E_icode == IOPQ) & ~exc_m & ~exc_w;
        if (exc_w) begin
          state_d  = ST_HALTED;
          status_d = W_status;
        end
      end
      ST_HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        M_bubble = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    // Reset dominates the control outputs while it is held, not just at the next edge.
    if (reset) begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      W_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      set_cc   = 1'b0;
    end
  end

  assign halted     = (state_q == ST_HALTED);
  assign cpu_status = status_q;
  assign run_active = (state_q == ST_RUN) && !reset;

  sat_counter #(.CNT_W(CNT_W)) u_cyc (
    .clock(clock), .reset(reset), .inc(run_active), .count(cyc_count));
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clock(clock), .reset(reset), .inc(run_active & (F_stall | D_stall)), .count(stall_count));
  sat_counter #(.CNT_W(CNT_W)) u_bubble (
    .clock(clock), .reset(reset), .inc(run_active & (D_bubble | E_bubble | M_bubble)),
    .count(bubble_count));
  sat_counter #(.CNT_W(CNT_W)) u_mispred (
    .clock(clock), .reset(reset), .inc(run_active & mispred), .count(mispredict_count));
endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: a rule-level model plus directed literal checks,
// run on a 32-bit-counter instance and a 4-bit-counter instance in parallel.
module tb_pipeline_control;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] D_icode, E_icode, M_icode, E_dstm, d_srca, d_srcb;
  logic       e_cnd;
  logic [1:0] m_status, W_status;

  logic        a_F, a_D, a_W, a_Db, a_Eb, a_Mb, a_cc, a_halted;
  logic [1:0]  a_status;
  logic [31:0] a_cyc, a_stall, a_bub, a_mp;
  logic        b_F, b_D, b_W, b_Db, b_Eb, b_Mb, b_cc, b_halted;
  logic [1:0]  b_status;
  logic [3:0]  b_cyc, b_stall, b_bub, b_mp;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  pipeline_control #(.CNT_W(32)) u_dut (
    .clock(clock), .reset(reset), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .E_dstm(E_dstm), .d_srca(d_srca), .d_srcb(d_srcb), .e_cnd(e_cnd),
    .m_status(m_status), .W_status(W_status),
    .F_stall(a_F), .D_stall(a_D), .W_stall(a_W), .D_bubble(a_Db), .E_bubble(a_Eb),
    .M_bubble(a_Mb), .set_cc(a_cc), .halted(a_halted), .cpu_status(a_status),
    .cyc_count(a_cyc), .stall_count(a_stall), .bubble_count(a_bub), .mispredict_count(a_mp));

  pipeline_control #(.CNT_W(4)) u_sat (
    .clock(clock), .reset(reset), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .E_dstm(E_dstm), .d_srca(d_srca), .d_srcb(d_srcb), .e_cnd(e_cnd),
    .m_status(m_status), .W_status(W_status),
    .F_stall(b_F), .D_stall(b_D), .W_stall(b_W), .D_bubble(b_Db), .E_bubble(b_Eb),
    .M_bubble(b_Mb), .set_cc(b_cc), .halted(b_halted), .cpu_status(b_status),
    .cyc_count(b_cyc), .stall_count(b_stall), .bubble_count(b_bub), .mispredict_count(b_mp));

  // Expected controls {F_stall,D_stall,W_stall,D_bubble,E_bubble,M_bubble,set_cc}.
  function automatic logic [6:0] exp_ctl(input logic rst, input logic h,
      input logic [3:0] di, input logic [3:0] ei, input logic [3:0] mi,
      input logic [3:0] edm, input logic [3:0] sa, input logic [3:0] sb,
      input logic ec, input logic [1:0] ms, input logic [1:0] ws);
    logic lu, rp, mp, em, ew;
    if (rst) return 7'b000_111_0;
    if (h)   return 7'b111_001_0;
    lu = (ei == 4'd5 || ei == 4'd11) && edm != 4'hF && (edm == sa || edm == sb);
    rp = (di == 4'd9) || (ei == 4'd9) || (mi == 4'd9);
    mp = (ei == 4'd7) && !ec;
    em = ms != 2'd0;
    ew = ws != 2'd0;
    return {lu | rp, lu, ew, mp | (rp & !lu), mp | lu, em | ew, (ei == 4'd6) & !em & !ew};
  endfunction

  function automatic logic [63:0] sat4(input int unsigned v);
    return (v > 15) ? 64'd15 : 64'(v);
  endfunction

  logic        m_halt;
  logic [1:0]  m_stat;
  int unsigned m_cyc, m_stall, m_bub, m_mp;
  logic [6:0]  exp_now, a_ctl, b_ctl;

  assign exp_now = exp_ctl(reset, m_halt, D_icode, E_icode, M_icode, E_dstm, d_srca, d_srcb,
                           e_cnd, m_status, W_status);
  assign a_ctl = {a_F, a_D, a_W, a_Db, a_Eb, a_Mb, a_cc};
  assign b_ctl = {b_F, b_D, b_W, b_Db, b_Eb, b_Mb, b_cc};

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_halt <= 1'b0; m_stat <= 2'd0;
      m_cyc <= 0; m_stall <= 0; m_bub <= 0; m_mp <= 0;
    end else if (!m_halt) begin
      m_cyc <= m_cyc + 1;
      if (exp_now[6] | exp_now[5]) m_stall <= m_stall + 1;
      if (exp_now[3] | exp_now[2] | exp_now[1]) m_bub <= m_bub + 1;
      if (E_icode == 4'd7 && !e_cnd) m_mp <= m_mp + 1;
      if (W_status != 2'd0) begin
        m_halt <= 1'b1;
        m_stat <= W_status;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
  endtask

  always @(negedge clock) begin
    check("ctl32", 64'(a_ctl), 64'(exp_now));
    check("ctl4", 64'(b_ctl), 64'(exp_now));
    check("halted", {62'd0, b_halted, a_halted}, {62'd0, m_halt, m_halt});
    check("cpu_status", {60'd0, b_status, a_status}, {60'd0, m_stat, m_stat});
    check("cyc32", 64'(a_cyc), 64'(m_cyc));
    check("stall32", 64'(a_stall), 64'(m_stall));
    check("bubble32", 64'(a_bub), 64'(m_bub));
    check("mispred32", 64'(a_mp), 64'(m_mp));
    check("cyc4", 64'(b_cyc), sat4(m_cyc));
    check("stall4", 64'(b_stall), sat4(m_stall));
    check("bubble4", 64'(b_bub), sat4(m_bub));
    check("mispred4", 64'(b_mp), sat4(m_mp));
  end

  task automatic set_nop();
    D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1;
    E_dstm = 4'hF; d_srca = 4'hF; d_srcb = 4'hF;
    e_cnd = 1'b1; m_status = 2'd0; W_status = 2'd0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset pulse placed mid-cycle; returns at posedge+7 with reset low and NOP inputs.
  task automatic do_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    set_nop();
    #1;
    check("rst_ctl", 64'(a_ctl), 64'b000_111_0);
    check("rst_halted", 64'(a_halted), 64'd0);
    check("rst_status", 64'(a_status), 64'd0);
    check("rst_cyc", 64'(a_cyc), 64'd0);
    #4 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_nop();
    #12 reset = 1'b0;

    // Mispredict, then taken branch.
    do_reset();
    E_icode = 4'd7; e_cnd = 1'b0;
    #1 check("mp_bubbles", {62'd0, a_Db, a_Eb}, 64'b11);
    step();
    check("mp_count", 64'(a_mp), 64'd1);
    check("mp_cyc", 64'(a_cyc), 64'd1);
    check("mp_bub", 64'(a_bub), 64'd1);
    e_cnd = 1'b1;
    #1 check("taken_bubbles", {62'd0, a_Db, a_Eb}, 64'b00);
    step();
    check("taken_count", 64'(a_mp), 64'd1);
    check("taken_cyc", 64'(a_cyc), 64'd2);

    // Load-use.
    E_icode = 4'd5; E_dstm = 4'd3; d_srca = 4'd3;
    #1 check("lu_ctl", {60'd0, a_F, a_D, a_Eb, a_Db}, 64'b1110);
    step();
    check("lu_stall", 64'(a_stall), 64'd1);
    set_nop();

    // Ret walking D -> E -> M.
    D_icode = 4'd9;
    #1 check("ret_d", {62'd0, a_F, a_Db}, 64'b11);
    step();
    D_icode = 4'd1; E_icode = 4'd9;
    #1 check("ret_e", {62'd0, a_F, a_Db}, 64'b11);
    step();
    E_icode = 4'd1; M_icode = 4'd9;
    #1 check("ret_m", {62'd0, a_F, a_Db}, 64'b11);
    step();
    M_icode = 4'd1;
    #1 check("ret_done", {62'd0, a_F, a_Db}, 64'b00);

    // Saturation: 20 load-use cycles.
    do_reset();
    E_icode = 4'd5; E_dstm = 4'd3; d_srca = 4'd3;
    for (int i = 0; i < 20; i++) step();
    check("sat_stall4", 64'(b_stall), 64'd15);
    check("sat_cyc4", 64'(b_cyc), 64'd15);
    check("sat_stall32", 64'(a_stall), 64'd20);

    // Exception in M, then W, then halt.
    do_reset();
    m_status = 2'd2; E_icode = 4'd6;
    #1 check("exc_m", {62'd0, a_Mb, a_cc}, 64'b10);
    step();
    m_status = 2'd0; E_icode = 4'd1; W_status = 2'd2;
    #1 check("exc_w_stall", 64'(a_W), 64'd1);
    step();
    check("halt_flag", 64'(a_halted), 64'd1);
    check("halt_status", 64'(a_status), 64'd2);
    W_status = 2'd0;
    for (int i = 0; i < 10; i++) begin
      E_icode = 4'd7; e_cnd = 1'b0;
      step();
      check("frozen_cyc", 64'(a_cyc), 64'd2);
      check("frozen_bub", 64'(a_bub), 64'd2);
      check("frozen_mp", 64'(a_mp), 64'd0);
      check("halt_ctl", 64'(a_ctl), 64'b111_001_0);
    end
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("rst_halt_flag", 64'(a_halted), 64'd0);
    check("rst_halt_status", 64'(a_status), 64'd0);
    check("rst_halt_bubbles", {61'd0, a_Db, a_Eb, a_Mb}, 64'b111);
    #2 reset = 1'b0;
    set_nop();

    // Randomized bursts.
    for (int b = 0; b < 4; b++) begin
      do_reset();
      for (int i = 0; i < 200; i++) begin
        step();
        D_icode = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 11));
        E_icode = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? 4'd5 : 4'd11)
                                              : 4'($urandom_range(0, 11));
        M_icode = 4'($urandom_range(0, 11));
        E_dstm  = 4'($urandom_range(0, 15));
        d_srca  = ($urandom_range(0, 2) == 0) ? E_dstm : 4'($urandom_range(0, 15));
        d_srcb  = ($urandom_range(0, 3) == 0) ? E_dstm : 4'($urandom_range(0, 15));
        e_cnd   = 1'($urandom_range(0, 1));
        m_status = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        W_status = ($urandom_range(0, 149) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      end
    end
    step();
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
